// File: rtl/int_controller_pkg.sv
// Shared widths, IDs and the lowest-ID priority encoder for the external
// interrupt controller.
package int_controller_pkg;
  localparam int INT_ID_W        = 5;
  localparam int INT_MAX_SOURCES = 31;
  localparam logic [INT_ID_W-1:0] INT_ID_NONE = '0;

  // Bit i of vec is source i+1; returns the lowest set source ID or none.
  function automatic logic [INT_ID_W-1:0] int_lowest_id(input logic [INT_MAX_SOURCES-1:0] vec);
    logic [INT_ID_W-1:0] id;
    id = INT_ID_NONE;
    for (int i = INT_MAX_SOURCES - 1; i >= 0; i--)
      if (vec[i]) id = INT_ID_W'(i + 1);
    return id;
  endfunction
endpackage

// File: rtl/int_sync.sv
// Two-flop synchroniser for one interrupt line plus a history flop that
// turns the synchronised level into a single-cycle rising-edge pulse.
module int_sync (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic level,
  output logic rise
);
  logic sync1_q, sync2_q, prev_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= async_in;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign level = sync2_q;
  assign rise  = sync2_q & ~prev_q;
endmodule

// File: rtl/int_controller.sv
// External interrupt controller: synchronise, latch pending (edge/level),
// mask, and hand the lowest eligible source to the core via claim/complete.
module int_controller
  import int_controller_pkg::*;
#(
  parameter int NUM_SOURCES = 8,
  parameter logic [INT_MAX_SOURCES-1:0] EDGE_MASK = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_SOURCES-1:0] src_irq,
  input  logic                   en_we,
  input  logic [NUM_SOURCES-1:0] en_wdata,
  output logic [NUM_SOURCES-1:0] en_mask,
  input  logic                   claim_req,
  output logic [INT_ID_W-1:0]    claim_id,
  input  logic                   complete_valid,
  input  logic [INT_ID_W-1:0]    complete_id,
  output logic                   ext_int
);
  if (NUM_SOURCES < 1 || NUM_SOURCES > INT_MAX_SOURCES) begin : g_bad_cfg
    $error("int_controller: NUM_SOURCES must be in 1..%0d", INT_MAX_SOURCES);
  end

  logic [NUM_SOURCES-1:0] level, rise, eligible;
  logic [NUM_SOURCES-1:0] pending_q, pending_d, in_service_q, in_service_d;
  logic [NUM_SOURCES-1:0] en_mask_q, en_mask_d;
  logic [INT_ID_W-1:0]    claim_id_q, claim_id_d, win_id;
  logic                   ext_int_q, ext_int_d;

  for (genvar i = 0; i < NUM_SOURCES; i++) begin : g_src
    int_sync u_sync (
      .clk      (clk),
      .reset    (reset),
      .async_in (src_irq[i]),
      .level    (level[i]),
      .rise     (rise[i])
    );
  end

  assign eligible = pending_q & en_mask_q & ~in_service_q;
  assign win_id   = int_lowest_id(INT_MAX_SOURCES'(eligible));

  always_comb begin
    pending_d    = pending_q;
    in_service_d = in_service_q;
    for (int i = 0; i < NUM_SOURCES; i++) begin
      // Clearing a bit that is already 0 is a no-op, so stray completes vanish.
      if (complete_valid && complete_id == INT_ID_W'(i + 1)) in_service_d[i] = 1'b0;
      if (claim_req && win_id == INT_ID_W'(i + 1))           in_service_d[i] = 1'b1;
      if (EDGE_MASK[i]) begin
        if (claim_req && win_id == INT_ID_W'(i + 1)) pending_d[i] = 1'b0;
        if (rise[i])                                 pending_d[i] = 1'b1;
      end else begin
        pending_d[i] = level[i];
      end
    end
    claim_id_d = claim_req ? win_id : claim_id_q;
    en_mask_d  = en_we ? en_wdata : en_mask_q;
    ext_int_d  = |eligible;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending_q    <= '0;
      in_service_q <= '0;
      en_mask_q    <= '0;
      claim_id_q   <= INT_ID_NONE;
      ext_int_q    <= 1'b0;
    end else begin
      pending_q    <= pending_d;
      in_service_q <= in_service_d;
      en_mask_q    <= en_mask_d;
      claim_id_q   <= claim_id_d;
      ext_int_q    <= ext_int_d;
    end
  end

  assign en_mask  = en_mask_q;
  assign claim_id = claim_id_q;
  assign ext_int  = ext_int_q;
endmodule

// File: tb/tb_int_controller.sv
// Bench for int_controller: directed scenarios plus random traffic, all
// checked every cycle against a behavioural model of the controller.
module tb_int_controller;
  localparam int NS = 8;
  localparam logic [NS-1:0] EDGE = 8'hA5;   // sources 1,3,6,8 edge; 2,4,5,7 level

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [NS-1:0] src_irq = '0;
  logic          en_we = 1'b0;
  logic [NS-1:0] en_wdata = '0;
  logic [NS-1:0] en_mask;
  logic          claim_req = 1'b0;
  logic [4:0]    claim_id;
  logic          complete_valid = 1'b0;
  logic [4:0]    complete_id = '0;
  logic          ext_int;

  int n_pass = 0;
  int n_total = 0;

  int_controller #(.NUM_SOURCES(NS), .EDGE_MASK(31'(EDGE))) dut (
    .clk(clk), .reset(reset), .src_irq(src_irq), .en_we(en_we), .en_wdata(en_wdata),
    .en_mask(en_mask), .claim_req(claim_req), .claim_id(claim_id),
    .complete_valid(complete_valid), .complete_id(complete_id), .ext_int(ext_int)
  );

  always #5 clk = ~clk;

  // Model: line samples of the last three edges, plus per-source flags.
  logic [NS-1:0] m_h1, m_h2, m_h3, m_pend, m_isv, m_mask;
  logic [4:0]    m_cid;
  logic          m_ext;

  function automatic int lowest(input logic [NS-1:0] v);
    for (int i = 0; i < NS; i++) if (v[i]) return i + 1;
    return 0;
  endfunction

  task automatic model_reset();
    m_h1 = '0; m_h2 = '0; m_h3 = '0;
    m_pend = '0; m_isv = '0; m_mask = '0;
    m_cid = '0; m_ext = 1'b0;
  endtask

  task automatic model_edge();
    logic [NS-1:0] elig, npend, nisv;
    int win, cid;
    elig = m_pend & m_mask & ~m_isv;
    win  = lowest(elig);
    for (int i = 0; i < NS; i++) begin
      if (EDGE[i])
        npend[i] = (m_h2[i] & ~m_h3[i]) | (m_pend[i] & !(claim_req && win == i + 1));
      else
        npend[i] = m_h2[i];
    end
    nisv = m_isv;
    cid  = int'(complete_id);
    if (complete_valid && cid >= 1 && cid <= NS && m_isv[cid-1]) nisv[cid-1] = 1'b0;
    if (claim_req && win != 0) nisv[win-1] = 1'b1;
    if (claim_req) m_cid = 5'(win);
    m_ext = |elig;
    if (en_we) m_mask = en_wdata;
    m_pend = npend;
    m_isv  = nisv;
    m_h3 = m_h2; m_h2 = m_h1; m_h1 = src_irq;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset) model_reset(); else model_edge();
    #1;
    check("claim_id", 32'(claim_id), 32'(m_cid));
    check("ext_int",  32'(ext_int),  32'(m_ext));
    check("en_mask",  32'(en_mask),  32'(m_mask));
  endtask

  task automatic write_mask(input logic [NS-1:0] m);
    en_we = 1'b1; en_wdata = m; tick(); en_we = 1'b0;
  endtask

  task automatic do_claim();
    claim_req = 1'b1; tick(); claim_req = 1'b0;
  endtask

  task automatic do_complete(input int id);
    complete_valid = 1'b1; complete_id = 5'(id); tick(); complete_valid = 1'b0;
  endtask

  task automatic pulse(input logic [NS-1:0] bits);
    src_irq = src_irq | bits; tick(); src_irq = src_irq & ~bits;
  endtask

  task automatic async_reset();
    #2 reset = 1'b1;
    #1 model_reset();
    check("rst_claim_id", 32'(claim_id), 32'd0);
    check("rst_ext_int",  32'(ext_int),  32'd0);
    check("rst_en_mask",  32'(en_mask),  32'd0);
    tick();
    reset = 1'b0;
  endtask

  initial begin
    model_reset();
    #1;
    check("reset_claim_id", 32'(claim_id), 32'd0);
    check("reset_ext_int",  32'(ext_int),  32'd0);
    check("reset_en_mask",  32'(en_mask),  32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Edge source 1: four edges to ext_int, claim, drop two edges after claim.
    write_mask(8'h05);
    repeat (2) tick();
    pulse(8'h01);
    repeat (2) tick();
    check("t1_ext_not_yet", 32'(ext_int), 32'd0);
    tick();
    check("t1_ext_after_4", 32'(ext_int), 32'd1);
    do_claim();
    check("t1_claim_id", 32'(claim_id), 32'd1);
    tick();
    check("t1_ext_dropped", 32'(ext_int), 32'd0);
    do_complete(1);

    // Sources 1 and 3 together: priority order then empty claim.
    pulse(8'h05);
    repeat (4) tick();
    do_claim(); check("t2_first", 32'(claim_id), 32'd1);
    do_claim(); check("t2_second", 32'(claim_id), 32'd3);
    do_claim(); check("t2_empty", 32'(claim_id), 32'd0);
    do_complete(1);
    do_complete(3);

    // Level source 2 held: masked while in service, back after complete.
    write_mask(8'h07);
    src_irq[1] = 1'b1;
    repeat (4) tick();
    check("t3_ext_level", 32'(ext_int), 32'd1);
    do_claim(); check("t3_claim", 32'(claim_id), 32'd2);
    repeat (3) tick();
    check("t3_ext_in_service", 32'(ext_int), 32'd0);
    do_complete(2);
    check("t3_ext_d", 32'(ext_int), 32'd0);
    tick();
    check("t3_ext_d1", 32'(ext_int), 32'd1);
    src_irq[1] = 1'b0;
    repeat (5) tick();
    check("t3_ext_released", 32'(ext_int), 32'd0);

    // New edge on source 1 in the same cycle it is claimed.
    pulse(8'h01);
    repeat (3) tick();
    src_irq[0] = 1'b1;
    repeat (2) tick();
    do_claim(); check("t4_claim", 32'(claim_id), 32'd1);
    tick();
    check("t4_ext_in_service", 32'(ext_int), 32'd0);
    src_irq[0] = 1'b0;
    do_complete(1);
    tick();
    check("t4_ext_reassert", 32'(ext_int), 32'd1);
    do_claim(); check("t4_reclaim", 32'(claim_id), 32'd1);
    do_complete(1);

    // Source 4 pending but masked, then enabled.
    write_mask(8'h00);
    src_irq[3] = 1'b1;
    repeat (5) tick();
    check("t5_ext_masked", 32'(ext_int), 32'd0);
    do_claim(); check("t5_claim_masked", 32'(claim_id), 32'd0);
    write_mask(8'h08);
    check("t5_ext_e", 32'(ext_int), 32'd0);
    tick();
    check("t5_ext_e1", 32'(ext_int), 32'd1);
    src_irq[3] = 1'b0;
    repeat (5) tick();

    // Reset mid-cycle with source 1 in service, then a stray complete.
    write_mask(8'h01);
    pulse(8'h01);
    repeat (4) tick();
    do_claim(); check("t6_claim", 32'(claim_id), 32'd1);
    async_reset();
    do_complete(1);
    write_mask(8'h01);
    pulse(8'h01);
    repeat (4) tick();
    do_claim(); check("t6_claim_after_reset", 32'(claim_id), 32'd1);

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      src_irq        = src_irq ^ NS'($urandom & $urandom & $urandom);
      en_we          = ($urandom_range(0, 15) == 0);
      en_wdata       = NS'($urandom | $urandom);
      claim_req      = ($urandom_range(0, 3) == 0);
      complete_valid = ($urandom_range(0, 2) == 0);
      complete_id    = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31))
                                                   : 5'($urandom_range(1, NS));
      if ($urandom_range(0, 599) == 0) async_reset();
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
